instruction_sram_param: RTL and testbench
=========================================

Name: instruction_sram_param

Overview:
Parametrised single-port instruction SRAM, successor to the fixed 32x32 instruction memory. Adds configurable width and depth, per-byte write masking, and a 1- or 2-stage read pipeline with a valid strobe. Also adds a post-reset zero-fill sequencer, so the memory holds deterministic contents before the instruction loader or fetch stage touches it. Sits between the instruction loader (write side) and the fetch stage (read side).

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
DEPTH, 32, number of words; need not be a power of 2
ADDR_W, $clog2(DEPTH) (min 1), address width; derived localparam, not overridable
BE_W, DATA_W/8, byte-enable width; derived localparam
RD_LAT, 1, read latency in clock edges; legal values are 1 and 2
INIT_CLEAR, 1, when 1, zero-fill all words after reset; when 0, contents are undefined and the block is ready immediately

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
ceb  in  1  chip enable, active low
web  in  1  write enable, active low (0 = write, 1 = read)
bweb  in  BE_W  byte write enable, active low; bit i covers D[8i+7:8i]
A  in  ADDR_W  word address
D  in  DATA_W  write data
Q  out  DATA_W  read data, registered
q_valid  out  1  high for one cycle when Q carries a new read result
ready  out  1  high when the sequencer is done and accesses are accepted

Behaviour:
- Reset (asynchronous, active-high):
  - Q=0, q_valid=0, all pipeline stages cleared.
  - ready=0 and FSM=CLEAR if INIT_CLEAR=1; otherwise ready=1 and FSM=RUN.
  - Memory contents are not reset directly.
- FSM states:
  - CLEAR: clr_cnt starts at 0. Each cycle writes 0 to mem[clr_cnt] and increments clr_cnt. When clr_cnt==DEPTH-1, the write happens and FSM moves to RUN.
  - RUN: terminal state; exits only on rst.
- ready is registered and equals (state==RUN). After rst deasserts, the clear takes exactly DEPTH cycles, and ready rises on the edge that writes the last word.
- Reset mid-CLEAR restarts clr_cnt at 0.
- While ready=0, ceb/web/A/D/bweb are ignored: no write, no read, q_valid stays 0.
- Write, when ready & !ceb & !web & A<DEPTH: for each i with bweb[i]==0, mem[A][8i+7:8i] <= D[8i+7:8i]. Other bytes are unchanged. bweb all-ones means no change.
- Read, when ready & !ceb & web:
  - Stage-1 register captures mem[A] (or 0 if A>=DEPTH).
  - RD_LAT=1: Q and q_valid update at that same edge.
  - RD_LAT=2: an extra register stage; Q and q_valid update one edge later.
- Reads sustain one per cycle. Back-to-back reads give back-to-back q_valid pulses, in order, with no bubbles.
- When no read completes in a cycle, Q holds its last value and q_valid=0. Q is never high-Z or X after reset.
- Write to address X in cycle n, then read of X in cycle n+1: returns the new data, including the merged masked bytes.
- Single port: one access per cycle; read vs write is chosen by web.
- Out-of-range address (A>=DEPTH, only possible when DEPTH is not a power of 2): write is dropped; read returns 0 with q_valid=1.
- An RD_LAT outside {1,2} is an elaboration-time error.

Decomposition:
- Package instr_mem_pkg:
  - state enum {CLEAR, RUN}
  - BYTE_W=8 constant
  - clog2-with-min-1 helper function
- One natural sub-module: sram_rd_pipe. It holds the RD_LAT-deep data+valid register chain with async reset to 0, parametrised by DATA_W and RD_LAT.

Test Plan:
1. INIT_CLEAR=1, DEPTH=32: pulse rst, then release -> ready=0 for exactly 32 cycles, then 1. Read all 32 addresses -> every Q=0, with 32 consecutive q_valid pulses.
2. During CLEAR, drive ceb=0, web=0, A=5, D=32'hDEADBEEF -> no effect. After ready, read A=5 -> Q=0.
3. Write A=3 with D=32'h11223344 and bweb=4'b0000, then A=3 with D=32'hAABBCCDD and bweb=4'b1010 -> read A=3 gives 32'h11BB33DD. Q appears 1 cycle after the read edge (RD_LAT=1) or 2 cycles after (RD_LAT=2).
4. Back-to-back reads of A=0,1,2 (preloaded 1,2,3) with RD_LAT=2 -> Q=1,2,3 on three consecutive cycles with q_valid high. Then ceb=1 -> q_valid=0 and Q holds 3.
5. DEPTH=20: write A=25 with D=32'hFFFFFFFF, then read A=25 -> Q=0 with q_valid=1. A read of A=19 is unaffected.
6. Assert rst at clear cycle 10, release -> ready stays low a full DEPTH cycles from the release. Assert rst during a pending RD_LAT=2 read -> Q=0 and q_valid=0 immediately, and no stale pulse follows.

Source files
------------

// File: rtl/instruction_sram_param_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the parametrised instruction SRAM:
//   state_t     - sequencer state (CLEAR while zero-filling, RUN afterwards)
//   BYTE_W      - width of one byte lane covered by a byte-enable bit
//   clog2_min1  - address width helper that never returns 0
// ---------------------------------------------------------------------------
package instr_mem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // A single-word memory still needs a 1-bit address port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/instruction_sram_param_rd_pipe.sv
// ---------------------------------------------------------------------------
// sram_rd_pipe
// RD_LAT-deep data + valid register chain for the SRAM read path.
// Stage 0 captures the raw array read; the last stage drives Q / q_valid.
// Data registers only load when their input stage is valid, so the output
// holds the last result between reads.
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset, clears every stage to 0
//   in_valid_i   a read is being accepted this cycle
//   in_data_i    raw array read data for that read
//   out_data_o   registered read data (RD_LAT edges after acceptance)
//   out_valid_o  one-cycle strobe marking a new result on out_data_o
// ---------------------------------------------------------------------------
module sram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid_i;
      if (in_valid_i) dat_q[0] <= in_data_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_data_o  = dat_q[RD_LAT-1];
  assign out_valid_o = vld_q[RD_LAT-1];

endmodule

// File: rtl/instruction_sram_param.sv
// ---------------------------------------------------------------------------
// instruction_sram_param
// Single-port instruction SRAM with per-byte write mask, 1- or 2-stage
// registered read and an optional post-reset zero-fill sequencer.
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst      asynchronous active-high reset
//   ceb      chip enable, active low
//   web      write enable, active low (0 = write, 1 = read)
//   bweb     byte write enable, active low; bit i covers D[8i+7:8i]
//   A        word address
//   D        write data
//   Q        registered read data, holds between reads
//   q_valid  one-cycle strobe when Q carries a new read result
//   ready    high once the zero-fill is done and accesses are accepted
// ---------------------------------------------------------------------------
module instruction_sram_param
  import instr_mem_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int DEPTH      = 32,
  parameter  int RD_LAT     = 1,
  parameter  int INIT_CLEAR = 1,
  localparam int ADDR_W     = clog2_min1(DEPTH),
  localparam int BE_W       = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ceb,
  input  logic              web,
  input  logic [BE_W-1:0]   bweb,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              q_valid,
  output logic              ready
);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("instruction_sram_param: RD_LAT must be 1 or 2");
  end
  if (DATA_W % BYTE_W != 0) begin : g_bad_data_w
    $error("instruction_sram_param: DATA_W must be a multiple of 8");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam state_t            RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : RUN;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;
  logic              clr_we;

  // ---------------- zero-fill sequencer ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      ready_q   <= (RESET_STATE == RUN);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        // The last word is written on the same edge that enters RUN.
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = RUN;
          clr_cnt_d = '0;
        end
      end
      RUN:     ;
      default: state_d = RESET_STATE;
    endcase
    ready_d = (state_d == RUN);
  end

  assign ready = ready_q;

  // ---------------- access decode ----------------
  // Widen before comparing so a power-of-2 DEPTH does not truncate to 0.
  logic in_range;
  logic wr_en, rd_en;

  assign in_range = ({1'b0, A} < (ADDR_W + 1)'(DEPTH));
  assign wr_en    = ready_q & ~ceb & ~web & in_range;
  assign rd_en    = ready_q & ~ceb & web;

  // ---------------- storage ----------------
  // NOTE: the array has no reset; deterministic contents come from the
  // zero-fill sequencer, keeping this mappable onto an SRAM macro.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (!bweb[i]) mem[A][i*BYTE_W +: BYTE_W] <= D[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Out-of-range reads still complete, returning zero.
  logic [DATA_W-1:0] rd_data;
  assign rd_data = in_range ? mem[A] : '0;

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_en),
    .in_data_i   (rd_data),
    .out_data_o  (Q),
    .out_valid_o (q_valid)
  );

endmodule

// File: tb/tb_instruction_sram_param.sv
// ---------------------------------------------------------------------------
// tb_instruction_sram_param
// Two instances share one stimulus stream:
//   u_dut0 : DEPTH=32, RD_LAT=1
//   u_dut1 : DEPTH=20, RD_LAT=2 (exercises out-of-range addresses)
// Each read pushes the hand-computed expected word and its due cycle into a
// per-instance queue; negedge monitors pop and compare on q_valid and check
// that Q holds between results.
// ---------------------------------------------------------------------------
module tb_instruction_sram_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        ceb, web;
  logic [3:0]  bweb;
  logic [4:0]  A;
  logic [31:0] D;
  logic [31:0] q0, q1;
  logic        q_valid0, q_valid1;
  logic        ready0, ready1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_sram_param #(
    .DATA_W(32), .DEPTH(32), .RD_LAT(1), .INIT_CLEAR(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .ceb(ceb), .web(web), .bweb(bweb), .A(A), .D(D),
    .Q(q0), .q_valid(q_valid0), .ready(ready0)
  );

  instruction_sram_param #(
    .DATA_W(32), .DEPTH(20), .RD_LAT(2), .INIT_CLEAR(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .ceb(ceb), .web(web), .bweb(bweb), .A(A), .D(D),
    .Q(q1), .q_valid(q_valid1), .ready(ready1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (q_valid0) begin
      if (sb0.size() == 0) check("dut0 unexpected q_valid", 32'd1, 32'd0);
      else begin
        e = sb0.pop_front();
        check("dut0 latency", cyc, e.due);
        check("dut0 Q", q0, e.data);
        last0 = e.data;
      end
    end else begin
      check("dut0 Q hold", q0, last0);
      if (sb0.size() != 0 && sb0[0].due <= cyc) begin
        check("dut0 missing q_valid", 32'd0, 32'd1);
        void'(sb0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_valid1) begin
      if (sb1.size() == 0) check("dut1 unexpected q_valid", 32'd1, 32'd0);
      else begin
        e = sb1.pop_front();
        check("dut1 latency", cyc, e.due);
        check("dut1 Q", q1, e.data);
        last1 = e.data;
      end
    end else begin
      check("dut1 Q hold", q1, last1);
      if (sb1.size() != 0 && sb1[0].due <= cyc) begin
        check("dut1 missing q_valid", 32'd0, 32'd1);
        void'(sb1.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic flush();
    sb0.delete();
    sb1.delete();
    last0 = '0;
    last1 = '0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(posedge clk); #1;
    ceb = 1'b0; web = 1'b0; A = addr; D = data; bweb = be;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] e0, input logic [31:0] e1);
    @(posedge clk); #1;
    ceb = 1'b0; web = 1'b1; A = addr; bweb = 4'hF;
    sb0.push_back('{due: cyc + 1, data: e0});
    sb1.push_back('{due: cyc + 2, data: e1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ceb = 1'b1; web = 1'b1;
    end
  endtask

  // Counts edges after reset release until each ready rises; optionally
  // drives writes/reads that must be ignored while the fill is running.
  task automatic measure_ready(input bit drive_ops, input string tag);
    int r0 = 0;
    int r1 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (r0 == 0 && ready0) r0 = k;
      if (r1 == 0 && ready1) r1 = k;
      if (drive_ops && k <= 18) begin
        ceb = 1'b0; A = 5'd5; D = 32'hDEADBEEF; bweb = 4'h0;
        web = (k <= 9) ? 1'b0 : 1'b1;
      end else begin
        ceb = 1'b1; web = 1'b1;
      end
    end
    check({tag, " dut0 ready edge"}, r0, 32);
    check({tag, " dut1 ready edge"}, r1, 20);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; ceb = 1'b1; web = 1'b1; bweb = 4'hF; A = '0; D = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dut0 ready", ready0, 0);
    check("reset dut1 ready", ready1, 0);
    check("reset dut0 Q", q0, 0);
    check("reset dut1 Q", q1, 0);
    check("reset dut0 q_valid", q_valid0, 0);
    check("reset dut1 q_valid", q_valid1, 0);
    rst = 1'b0;

    // Fill duration, with accesses attempted during the fill.
    measure_ready(1'b1, "init");

    // Every word zero after the fill; dut1 addresses 20..31 are out of range.
    for (int a = 0; a < 32; a++) rd(5'(a), 32'h0, 32'h0);
    rd(5'd5, 32'h0, 32'h0);
    idle(3);

    // Full write, masked write, immediate read-back.
    wr(5'd3, 32'h11223344, 4'b0000);
    wr(5'd3, 32'hAABBCCDD, 4'b1010);
    rd(5'd3, 32'h11BB33DD, 32'h11BB33DD);
    idle(3);

    // Back-to-back reads, then idle: Q must hold 3.
    wr(5'd0, 32'd1, 4'b0000);
    wr(5'd1, 32'd2, 4'b0000);
    wr(5'd2, 32'd3, 4'b0000);
    rd(5'd0, 32'd1, 32'd1);
    rd(5'd1, 32'd2, 32'd2);
    rd(5'd2, 32'd3, 32'd3);
    idle(4);
    check("hold dut0 Q", q0, 32'd3);
    check("hold dut1 Q", q1, 32'd3);
    check("hold dut0 q_valid", q_valid0, 0);
    check("hold dut1 q_valid", q_valid1, 0);

    // Address 25: in range for dut0, dropped on write / zero on read for dut1.
    wr(5'd25, 32'hFFFFFFFF, 4'b0000);
    rd(5'd25, 32'hFFFFFFFF, 32'h0);
    wr(5'd19, 32'h13579BDF, 4'b0000);
    wr(5'd19, 32'h00000000, 4'b1111);
    rd(5'd19, 32'h13579BDF, 32'h13579BDF);
    idle(3);

    // Reset in the middle of the fill restarts it from zero.
    @(posedge clk); #1;
    rst = 1'b1; flush();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; flush();
    #1;
    check("mid-clear dut0 ready", ready0, 0);
    check("mid-clear dut1 ready", ready1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    measure_ready(1'b0, "restart");
    rd(5'd3, 32'h0, 32'h0);
    rd(5'd25, 32'h0, 32'h0);
    idle(3);

    // Reset with a read still in flight in the 2-stage pipe.
    wr(5'd7, 32'hCAFEF00D, 4'b0000);
    rd(5'd7, 32'hCAFEF00D, 32'hCAFEF00D);
    @(posedge clk); #2;
    ceb = 1'b1; web = 1'b1;
    rst = 1'b1; flush();
    #1;
    check("inflight rst dut0 Q", q0, 0);
    check("inflight rst dut1 Q", q1, 0);
    check("inflight rst dut0 q_valid", q_valid0, 0);
    check("inflight rst dut1 q_valid", q_valid1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(40);

    check("dut0 queue drained", sb0.size(), 0);
    check("dut1 queue drained", sb1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
